// File: rtl/heap_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// heap_cmd_sequencer
//
// Issue stage in front of the custom-instruction max-heap unit. Heap
// instructions from the core are buffered in a small command FIFO. They are
// dispatched one at a time as single-cycle push/pop strobes. The block then
// waits for the heap to finish re-heapifying and returns a tagged write-back
// to the core. A local mirror of heap occupancy lets push-on-full and
// pop-on-empty be rejected without ever reaching the heap.
//
// Ports
//   clk, reset          : single rising-edge clock, async active-high reset
//   in_v/in_ready       : command handshake from the core (nop is dropped)
//   in_op/in_rd/in_data : 00 nop, 01 push, 10 pop, 11 size query; tag; operand
//   push/pop/heap_data  : one-cycle strobes plus push operand to the heap
//   heap_busy           : heap is re-heapifying
//   heap_out_v/_data    : popped value returned by the heap
//   out_v/out_rd/out_data/out_err : one-cycle tagged write-back to the core
//   count               : occupancy mirror, 0..HEAP_SIZE
// -----------------------------------------------------------------------------
module heap_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int HEAP_SIZE  = 11,
  parameter int TIMEOUT    = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_v,
  output logic                           in_ready,
  input  logic [1:0]                     in_op,
  input  logic [4:0]                     in_rd,
  input  logic [31:0]                    in_data,
  output logic                           push,
  output logic                           pop,
  output logic [31:0]                    heap_data,
  input  logic                           heap_busy,
  input  logic                           heap_out_v,
  input  logic [31:0]                    heap_out_data,
  output logic                           out_v,
  output logic [4:0]                     out_rd,
  output logic [31:0]                    out_data,
  output logic                           out_err,
  output logic [$clog2(HEAP_SIZE+1)-1:0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(HEAP_SIZE + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int EW = 39;

  localparam logic [1:0]    OP_NOP   = 2'b00;
  localparam logic [1:0]    OP_PUSH  = 2'b01;
  localparam logic [1:0]    OP_POP   = 2'b10;
  localparam logic [1:0]    OP_QUERY = 2'b11;

  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(HEAP_SIZE);
  localparam logic [WW-1:0] WD_ZERO  = WW'(0);
  localparam logic [WW-1:0] WD_ONE   = WW'(1);
  localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ISSUED = 2'b01,
    S_WAIT   = 2'b10,
    S_RESP   = 2'b11
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          r_in_ready;

  logic          w_enq;
  logic          w_deq;
  logic          w_empty;
  logic [AW:0]   w_wptr_nxt;
  logic [AW:0]   w_rptr_nxt;
  logic          w_full_nxt;
  logic [EW-1:0] w_head;
  logic [1:0]    w_head_op;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;

  // Nops are swallowed at the door so they never cost a dispatch slot.
  assign w_enq       = in_v && r_in_ready && (in_op != OP_NOP);
  assign w_empty     = (r_wptr == r_rptr);
  assign w_wptr_nxt  = w_enq ? (r_wptr + PTR_ONE) : r_wptr;
  assign w_rptr_nxt  = w_deq ? (r_rptr + PTR_ONE) : r_rptr;
  // Full when the index bits match but the wrap bits differ.
  assign w_full_nxt  = (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                       (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
  assign w_head      = r_mem[r_rptr[AW-1:0]];
  assign w_head_op   = w_head[38:37];
  assign w_head_rd   = w_head[36:32];
  assign w_head_data = w_head[31:0];

  // FIFO storage write; payload only, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wptr[AW-1:0]] <= {in_op, in_rd, in_data};
    end
  end

  // FIFO pointers and the registered ready flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_wptr     <= w_wptr_nxt;
      r_rptr     <= w_rptr_nxt;
      r_in_ready <= ~w_full_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Dispatch FSM
  // ---------------------------------------------------------------------------
  state_t        r_state;
  logic [1:0]    r_op;
  logic [4:0]    r_rd;
  logic          r_cap_v;
  logic [31:0]   r_cap_data;
  logic [WW-1:0] r_wd;
  logic [CW-1:0] r_count;
  logic          r_push;
  logic          r_pop;
  logic [31:0]   r_heap_data;
  logic          r_out_v;
  logic [4:0]    r_out_rd;
  logic [31:0]   r_out_data;
  logic          r_out_err;

  state_t        w_state_nxt;
  logic          w_push_nxt;
  logic          w_pop_nxt;
  logic [31:0]   w_heap_data_nxt;
  logic          w_resp_v;
  logic [4:0]    w_resp_rd;
  logic [31:0]   w_resp_data;
  logic          w_resp_err;
  logic [CW-1:0] w_count_nxt;
  logic [WW-1:0] w_wd_nxt;
  logic          w_cap_v_nxt;
  logic [31:0]   w_cap_data_nxt;
  logic          w_cap_now;
  logic [31:0]   w_count_ext;

  assign w_count_ext = {{(32 - CW){1'b0}}, r_count};
  // A popped value seen this very cycle is good enough to leave WAIT.
  assign w_cap_now   = heap_out_v && (r_op == OP_POP);

  // Next-state, strobe and write-back decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_deq           = 1'b0;
    w_push_nxt      = 1'b0;
    w_pop_nxt       = 1'b0;
    w_heap_data_nxt = 32'd0;
    w_resp_v        = 1'b0;
    w_resp_rd       = 5'd0;
    w_resp_data     = 32'd0;
    w_resp_err      = 1'b0;
    w_count_nxt     = r_count;
    w_wd_nxt        = r_wd;
    w_cap_v_nxt     = r_cap_v;
    w_cap_data_nxt  = r_cap_data;

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_deq     = 1'b1;
          w_resp_rd = w_head_rd;
          case (w_head_op)
            OP_PUSH: begin
              if (r_count < CNT_MAX) begin
                w_push_nxt      = 1'b1;
                w_heap_data_nxt = w_head_data;
                w_state_nxt     = S_ISSUED;
              end else begin
                w_resp_v    = 1'b1;
                w_resp_err  = 1'b1;
                w_state_nxt = S_RESP;
              end
            end
            OP_POP: begin
              if (r_count != CNT_ZERO) begin
                w_pop_nxt   = 1'b1;
                w_state_nxt = S_ISSUED;
              end else begin
                w_resp_v    = 1'b1;
                w_resp_err  = 1'b1;
                w_state_nxt = S_RESP;
              end
            end
            OP_QUERY: begin
              w_resp_v    = 1'b1;
              w_resp_data = w_count_ext;
              w_state_nxt = S_RESP;
            end
            default: begin
              // Nops never enter the FIFO; reject defensively if one does.
              w_resp_v    = 1'b1;
              w_resp_err  = 1'b1;
              w_state_nxt = S_RESP;
            end
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_ISSUED: begin
        // Mirror tracks the heap as soon as the strobe has gone out.
        if (r_op == OP_PUSH) begin
          w_count_nxt = r_count + CNT_ONE;
        end else if (r_op == OP_POP) begin
          w_count_nxt = r_count - CNT_ONE;
        end else begin
          w_count_nxt = r_count;
        end
        w_wd_nxt    = WD_ZERO;
        w_cap_v_nxt = 1'b0;
        w_state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (w_cap_now) begin
          w_cap_v_nxt    = 1'b1;
          w_cap_data_nxt = heap_out_data;
        end else begin
          w_cap_v_nxt    = r_cap_v;
          w_cap_data_nxt = r_cap_data;
        end
        w_resp_rd = r_rd;
        if (!heap_busy && ((r_op != OP_POP) || r_cap_v || w_cap_now)) begin
          w_resp_v    = 1'b1;
          w_resp_data = (r_op == OP_POP) ? w_cap_data_nxt : w_count_ext;
          w_state_nxt = S_RESP;
        end else if (r_wd == WD_MAX) begin
          // Abandon the op; the heap already saw the strobe so count stays.
          w_resp_v    = 1'b1;
          w_resp_err  = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_wd_nxt    = r_wd + WD_ONE;
          w_state_nxt = S_WAIT;
        end
      end

      S_RESP: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, latched command, watchdog, occupancy mirror and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_NOP;
      r_rd        <= 5'd0;
      r_cap_v     <= 1'b0;
      r_cap_data  <= 32'd0;
      r_wd        <= WD_ZERO;
      r_count     <= CNT_ZERO;
      r_push      <= 1'b0;
      r_pop       <= 1'b0;
      r_heap_data <= 32'd0;
      r_out_v     <= 1'b0;
      r_out_rd    <= 5'd0;
      r_out_data  <= 32'd0;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      if (w_deq) begin
        r_op <= w_head_op;
        r_rd <= w_head_rd;
      end
      r_cap_v     <= w_cap_v_nxt;
      r_cap_data  <= w_cap_data_nxt;
      r_wd        <= w_wd_nxt;
      r_count     <= w_count_nxt;
      r_push      <= w_push_nxt;
      r_pop       <= w_pop_nxt;
      r_heap_data <= w_heap_data_nxt;
      r_out_v     <= w_resp_v;
      r_out_rd    <= w_resp_v ? w_resp_rd : 5'd0;
      r_out_data  <= w_resp_v ? w_resp_data : 32'd0;
      r_out_err   <= w_resp_v ? w_resp_err : 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign push      = r_push;
  assign pop       = r_pop;
  assign heap_data = r_heap_data;
  assign out_v     = r_out_v;
  assign out_rd    = r_out_rd;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign count     = r_count;

endmodule
